// File: rtl/ram_ctrl_pkg.sv
// rtl/ram_ctrl_pkg.sv - shared types and constants for the word-access RAM controller
package ram_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  localparam int NBYTES = 4;
  localparam int BEAT_W = 2;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-request round-robin arbiter with last-granted pointer
module rr_arb2 import ram_ctrl_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);
  logic last;

  // On a tie the master that was not granted last wins.
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = (last == M0) ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last <= M0;
    else if (update) last <= gnt[1] ? M1 : M0;
  end
endmodule

// File: rtl/ram_word_ctrl.sv
// rtl/ram_word_ctrl.sv - two-master word controller serialising accesses into byte beats on dram
module ram_word_ctrl import ram_ctrl_pkg::*; #(
  parameter int ADDR_W = 15,
  parameter int NBYTES = ram_ctrl_pkg::NBYTES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic [ADDR_W-1:0]     m0_addr,
  output logic                  m0_gnt,
  output logic                  m0_done,
  output logic [8*NBYTES-1:0]   m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [8*NBYTES-1:0]   m1_wdata,
  input  logic [NBYTES-1:0]     m1_be,
  output logic                  m1_gnt,
  output logic                  m1_done,
  output logic [8*NBYTES-1:0]   m1_rdata,
  output logic                  ram_wea,
  output logic [ADDR_W-1:0]     ram_addra,
  output logic [7:0]            ram_dina,
  output logic                  ram_enb,
  output logic [ADDR_W-1:0]     ram_addrb,
  input  logic [7:0]            ram_doutb
);
  state_t                state, state_nxt;
  logic [BEAT_W-1:0]     beat;
  logic                  owner, we_q;
  logic [ADDR_W-3:0]     waddr;
  logic [8*NBYTES-1:0]   wdata_q, rbuf, rword;
  logic [NBYTES-1:0]     be_q;
  logic [1:0]            arb_gnt;
  logic                  idle, accept, last_beat;
  logic [ADDR_W-1:0]     byte_addr;
  logic                  unused_addr_lsb;

  assign unused_addr_lsb = ^{m0_addr[1:0], m1_addr[1:0]};

  // Gating with rst_n keeps grants low while reset is asserted.
  assign idle      = (state == IDLE) && rst_n;
  assign accept    = |arb_gnt;
  assign m0_gnt    = arb_gnt[0];
  assign m1_gnt    = arb_gnt[1];
  assign last_beat = (beat == BEAT_W'(NBYTES - 1));
  assign byte_addr = {waddr, beat};

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({m1_req, m0_req} & {2{idle}}),
    .update (accept),
    .gnt    (arb_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ram_wea   = 1'b0;
    ram_addra = '0;
    ram_dina  = '0;
    ram_enb   = 1'b0;
    ram_addrb = '0;
    case (state)
      IDLE: if (accept) state_nxt = XFER;
      XFER: begin
        if (last_beat) state_nxt = RESP;
        if (we_q) begin
          ram_wea   = be_q[beat];
          ram_addra = byte_addr;
          ram_dina  = wdata_q[{beat, 3'b000} +: 8];
        end else begin
          ram_enb   = 1'b1;
          ram_addrb = byte_addr;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read word as it stands once the current beat's byte is merged in.
  always_comb begin
    rword = rbuf;
    rword[{beat, 3'b000} +: 8] = ram_doutb;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat     <= '0;
      owner    <= M0;
      we_q     <= 1'b0;
      waddr    <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      rbuf     <= '0;
      m0_done  <= 1'b0;
      m1_done  <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      if (accept) begin
        owner   <= arb_gnt[1] ? M1 : M0;
        we_q    <= arb_gnt[1] & m1_we;
        waddr   <= arb_gnt[1] ? m1_addr[ADDR_W-1:2] : m0_addr[ADDR_W-1:2];
        wdata_q <= m1_wdata;
        be_q    <= m1_be;
        beat    <= '0;
      end
      if (state == XFER) begin
        beat <= beat + 1'b1;
        if (!we_q) rbuf <= rword;
        if (last_beat) begin
          if (owner == M0) begin
            m0_done <= 1'b1;
            if (!we_q) m0_rdata <= rword;
          end else begin
            m1_done <= 1'b1;
            if (!we_q) m1_rdata <= rword;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_ram_word_ctrl.sv
// tb/tb_ram_word_ctrl.sv - directed-vector bench for ram_word_ctrl with a byte-wide RAM model
module tb_ram_word_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_gnt, m0_done;
  logic [14:0] m0_addr;
  logic [31:0] m0_rdata;
  logic        m1_req, m1_we, m1_gnt, m1_done;
  logic [14:0] m1_addr;
  logic [31:0] m1_wdata, m1_rdata;
  logic [3:0]  m1_be;
  logic        ram_wea, ram_enb;
  logic [14:0] ram_addra, ram_addrb;
  logic [7:0]  ram_dina, ram_doutb;

  logic [7:0]  mem [0:32767];
  int          vectors = 0;
  int          miscompares = 0;
  logic [3:0]  obs_wea, obs_enb;
  logic [14:0] obs_a0, obs_a3;

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_wea) mem[ram_addra] <= ram_dina;
  assign ram_doutb = mem[ram_addrb];

  ram_word_ctrl #(.ADDR_W(15), .NBYTES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata),
    .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
    .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_doutb(ram_doutb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One access from grant to done; beat-level RAM port activity is captured in obs_*.
  task automatic access(input logic m, input logic we, input logic [14:0] addr,
                        input logic [31:0] wd, input logic [3:0] be, input string tag);
    int n;
    @(negedge clk);
    if (m) begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wd; m1_be = be;
    end else begin
      m0_req = 1'b1; m0_addr = addr;
    end
    #1;
    n = 0;
    while (!(m ? m1_gnt : m0_gnt) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check({tag, "_gnt"}, {31'b0, (m ? m1_gnt : m0_gnt)}, 32'd1);
    @(posedge clk); #1;
    m0_req = 1'b0; m1_req = 1'b0;
    m0_addr = '1; m1_addr = '1; m1_wdata = 32'h0; m1_be = 4'h0; m1_we = ~we;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      obs_wea[k] = ram_wea;
      obs_enb[k] = ram_enb;
      if (k == 0) obs_a0 = we ? ram_addra : ram_addrb;
      if (k == 3) obs_a3 = we ? ram_addra : ram_addrb;
    end
    check({tag, "_early_done"}, {30'b0, m1_done, m0_done}, 32'd0);
    @(negedge clk); #1;
    check({tag, "_done"}, {30'b0, m1_done, m0_done}, m ? 32'd2 : 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [1:0] exp_gnt, exp_done;
    for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
    mem[15'h7FFC] = 8'h01; mem[15'h7FFD] = 8'h02; mem[15'h7FFE] = 8'h03; mem[15'h7FFF] = 8'h04;
    mem[15'h20] = 8'h11; mem[15'h21] = 8'h22; mem[15'h22] = 8'h55; mem[15'h23] = 8'h66;
    rst_n = 1'b0;
    m0_req = 1'b1; m0_addr = 15'h0;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 15'h0; m1_wdata = 32'h0; m1_be = 4'hF;

    repeat (2) @(negedge clk);
    #1;
    check("rst_gnt",   {30'b0, m1_gnt, m0_gnt}, 32'd0);
    check("rst_ports", {28'b0, ram_wea, ram_enb, m1_done, m0_done}, 32'd0);
    check("rst_rdata", m0_rdata | m1_rdata, 32'd0);
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    access(1'b1, 1'b1, 15'h0010, 32'hDEADBEEF, 4'hF, "wr1");
    check("wr1_mem", {mem[15'h13], mem[15'h12], mem[15'h11], mem[15'h10]}, 32'hDEADBEEF);
    check("wr1_wea", {28'b0, obs_wea}, 32'hF);
    access(1'b0, 1'b0, 15'h0010, 32'h0, 4'h0, "rd1");
    check("rd1_rdata", m0_rdata, 32'hDEADBEEF);
    check("rd1_enb", {28'b0, obs_enb}, 32'hF);

    access(1'b1, 1'b1, 15'h0010, 32'h11223344, 4'h5, "wr2");
    check("wr2_wea", {28'b0, obs_wea}, 32'h5);
    access(1'b1, 1'b0, 15'h0010, 32'h0, 4'h0, "rd2");
    check("rd2_rdata", m1_rdata, 32'hDE22BE44);
    check("rd2_m0_hold", m0_rdata, 32'hDEADBEEF);

    access(1'b1, 1'b1, 15'h0010, 32'hCAFEF00D, 4'hF, "wr3");
    check("wr3_m1_hold", m1_rdata, 32'hDE22BE44);
    access(1'b0, 1'b0, 15'h0013, 32'h0, 4'h0, "rd3");
    check("rd3_rdata", m0_rdata, 32'hCAFEF00D);
    access(1'b0, 1'b0, 15'h7FFC, 32'h0, 4'h0, "rd4");
    check("rd4_addr0", {17'b0, obs_a0}, 32'h7FFC);
    check("rd4_addr3", {17'b0, obs_a3}, 32'h7FFF);
    check("rd4_rdata", m0_rdata, 32'h04030201);

    // Reset during beat 2 of a full-word write.
    @(negedge clk);
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 15'h0020; m1_wdata = 32'hAABBCCDD; m1_be = 4'hF;
    #1;
    n = 0;
    while (!m1_gnt && n < 20) begin @(negedge clk); #1; n++; end
    check("abort_gnt", {31'b0, m1_gnt}, 32'd1);
    @(posedge clk); #1;
    m1_req = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("abort_beat2_wea", {31'b0, ram_wea}, 32'd1);
    rst_n = 1'b0;
    m0_req = 1'b1; m0_addr = 15'h0010;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 15'h7FFC;
    #1;
    check("abort_ports", {28'b0, ram_wea, ram_enb, m1_gnt, m0_gnt}, 32'd0);
    check("abort_data", {1'b0, ram_addra, ram_dina, 8'b0}, 32'd0);
    check("abort_rdata", m0_rdata | m1_rdata, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    check("abort_hold", {28'b0, m1_gnt, m0_gnt, m1_done, m0_done}, 32'd0);
    check("abort_mem", {mem[15'h23], mem[15'h22], mem[15'h21], mem[15'h20]}, 32'h6655CCDD);

    // Both masters requesting continuously from reset release.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp_gnt  = (i % 6 == 0) ? (((i / 6) % 2 == 0) ? 2'b10 : 2'b01) : 2'b00;
      exp_done = (i % 6 == 5) ? (((i / 6) % 2 == 0) ? 2'b10 : 2'b01) : 2'b00;
      check($sformatf("rr_gnt_%0d", i),  {30'b0, m1_gnt, m0_gnt}, {30'b0, exp_gnt});
      check($sformatf("rr_done_%0d", i), {30'b0, m1_done, m0_done}, {30'b0, exp_done});
      check($sformatf("rr_enb_%0d", i),  {30'b0, ram_wea, ram_enb},
            {31'b0, ((i % 6) >= 1 && (i % 6) <= 4)});
    end
    m0_req = 1'b0; m1_req = 1'b0;
    check("rr_m0_rdata", m0_rdata, 32'hCAFEF00D);
    check("rr_m1_rdata", m1_rdata, 32'h04030201);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
